adat_frame_scheduler: RTL and testbench

Feeds the circular frame buffer that the ADAT encoder reads. It accepts a stream of per-channel samples from the USB audio side and packs them into 32-bit words in the frame RAM, one 256-bit frame per slot. It tracks the encoder's read position from the encoder's RAM read address and publishes the index of the last fully written frame. It applies backpressure when the next slot is being transmitted, and recovers cleanly from underrun and channel misalignment.

---
 rtl/adat_frame_scheduler.sv | 157 +++++++++++++++
 tb/tb_adat_frame_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_scheduler.sv
// Packs per-channel USB audio samples into 256-bit frames in the ADAT encoder's circular frame RAM.
// Latency: RAM write one cycle after acceptance; frame index, underrun and resync pulses one cycle after cause.
// Backpressure: sample_ready_o low while the write slot equals the encoder read slot. Stats macro: ADAT_FRAME_SCHEDULER_STATS_EN.
module adat_frame_scheduler #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int CHANNELS      = 8,
  parameter int SAMPLE_BITS   = 24
) (
  input  logic                       clk_x4_i,
  input  logic                       rst_ni,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  input  logic                       sample_first_i,
  input  logic [SAMPLE_BITS-1:0]     sample_data_i,
  input  logic [CIRC_BUF_BITS+7:0]   enc_read_addr_i,
  output logic                       ram_wr_en_o,
  output logic [CIRC_BUF_BITS+2:0]   ram_wr_addr_o,
  output logic [31:0]                ram_wr_data_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic                       underrun_o,
  output logic                       resync_o,
  output logic [15:0]                overrun_cnt_o,
  output logic [15:0]                underrun_cnt_o
);

  localparam int SB = CIRC_BUF_BITS;
  localparam logic [2:0]    LAST_CH  = 3'(CHANNELS - 1);
  localparam logic [SB-1:0] SLOT_ONE = SB'(1);

  typedef enum logic {StWaitSync, StFill} state_t;

  state_t        state_q, state_d;
  logic [SB-1:0] wr_slot_q, wr_slot_d;
  logic [SB-1:0] last_good_q, last_good_d;
  logic [SB-1:0] rd_slot_in, rd_slot_q, rd_prev_q;
  logic [2:0]    ch_q, ch_d, wr_ch;
  logic          accept, do_write, resync_d, underrun_det, overrun;
  logic          unused_addr_bits;

  assign rd_slot_in       = enc_read_addr_i[SB+7:8];
  assign unused_addr_bits = ^enc_read_addr_i[7:0];

  // The encoder has just stepped onto the slot after the last complete frame.
  assign underrun_det = (rd_slot_q != rd_prev_q) && (rd_slot_q == last_good_q + SLOT_ONE);
  assign sample_ready_o = (state_q == StWaitSync) ? 1'b1 : (wr_slot_q != rd_slot_q);
  assign accept  = sample_valid_i && sample_ready_o;
  assign overrun = sample_valid_i && !sample_ready_o;

  // Next-state: frame alignment, channel counting, commit and underrun recovery.
  always_comb begin
    state_d     = state_q;
    wr_slot_d   = wr_slot_q;
    last_good_d = last_good_q;
    ch_d        = ch_q;
    wr_ch       = ch_q;
    do_write    = 1'b0;
    resync_d    = 1'b0;
    case (state_q)
      StWaitSync: begin
        if (accept && sample_first_i) begin
          do_write = 1'b1;
          wr_ch    = 3'd0;
          ch_d     = 3'd1;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (accept) begin
          if (sample_first_i && ch_q != 3'd0) begin
            // Restart the frame in the same slot; the partial data is overwritten.
            do_write = 1'b1;
            wr_ch    = 3'd0;
            ch_d     = 3'd1;
            resync_d = 1'b1;
          end else if (!sample_first_i && ch_q == 3'd0) begin
            state_d = StWaitSync;
          end else begin
            do_write = 1'b1;
            ch_d     = ch_q + 3'd1;
            if (ch_q == LAST_CH) begin
              last_good_d = wr_slot_q;
              wr_slot_d   = wr_slot_q + SLOT_ONE;
              ch_d        = 3'd0;
            end
          end
        end
      end
      default: state_d = StWaitSync;
    endcase
    // Underrun overrides everything, including a commit in the same cycle.
    if (underrun_det) begin
      state_d     = StWaitSync;
      wr_slot_d   = rd_slot_q + SLOT_ONE;
      ch_d        = 3'd0;
      last_good_d = last_good_q;
      do_write    = 1'b0;
      resync_d    = 1'b0;
    end
  end

  // State, read-slot tracking and registered RAM write port.
  always_ff @(posedge clk_x4_i) begin
    if (!rst_ni) begin
      state_q       <= StWaitSync;
      wr_slot_q     <= SLOT_ONE;
      last_good_q   <= '0;
      ch_q          <= 3'd0;
      rd_slot_q     <= rd_slot_in;
      rd_prev_q     <= rd_slot_in;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      underrun_o    <= 1'b0;
      resync_o      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_slot_q     <= wr_slot_d;
      last_good_q   <= last_good_d;
      ch_q          <= ch_d;
      rd_slot_q     <= rd_slot_in;
      rd_prev_q     <= rd_slot_q;
      ram_wr_en_o   <= do_write;
      ram_wr_addr_o <= {wr_slot_q, wr_ch};
      ram_wr_data_o <= {{(32-SAMPLE_BITS){1'b0}}, sample_data_i};
      underrun_o    <= underrun_det;
      resync_o      <= resync_d;
    end
  end

  assign last_good_frame_idx_o = last_good_q;

`ifdef ADAT_FRAME_SCHEDULER_STATS_EN
  logic [15:0] overrun_cnt_q, underrun_cnt_q;

  // Saturating stall and underrun statistics.
  always_ff @(posedge clk_x4_i) begin
    if (!rst_ni) begin
      overrun_cnt_q  <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (overrun && overrun_cnt_q != 16'hFFFF)
        overrun_cnt_q <= overrun_cnt_q + 16'd1;
      if (underrun_det && underrun_cnt_q != 16'hFFFF)
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign overrun_cnt_o  = overrun_cnt_q;
  assign underrun_cnt_o = underrun_cnt_q;
`else
  logic unused_overrun;
  assign unused_overrun = overrun;
  assign overrun_cnt_o  = 16'd0;
  assign underrun_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_adat_frame_scheduler.sv
// Directed bench for adat_frame_scheduler with a write scoreboard.
// Expected RAM writes are queued when a sample is accepted and popped on each write strobe.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_adat_frame_scheduler;

  logic        clk_x4_i = 1'b0;
  logic        rst_ni;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic        sample_first_i;
  logic [23:0] sample_data_i;
  logic [10:0] enc_read_addr_i;
  logic        ram_wr_en_o;
  logic [5:0]  ram_wr_addr_o;
  logic [31:0] ram_wr_data_o;
  logic [2:0]  last_good_frame_idx_o;
  logic        underrun_o;
  logic        resync_o;
  logic [15:0] overrun_cnt_o;
  logic [15:0] underrun_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [37:0] sb_q[$];

  adat_frame_scheduler dut (
    .clk_x4_i(clk_x4_i), .rst_ni(rst_ni),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sample_first_i(sample_first_i), .sample_data_i(sample_data_i),
    .enc_read_addr_i(enc_read_addr_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .last_good_frame_idx_o(last_good_frame_idx_o),
    .underrun_o(underrun_o), .resync_o(resync_o),
    .overrun_cnt_o(overrun_cnt_o), .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk_x4_i = ~clk_x4_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [2:0] s);
    enc_read_addr_i = {s, 8'h00};
  endtask

  // Offer one sample, wait for acceptance, and check the write strobe one cycle later.
  task automatic send(input logic [23:0] d, input logic f, input logic exp_wr, input logic [5:0] exp_addr);
    int n = 0;
    @(posedge clk_x4_i); #1;
    sample_valid_i = 1'b1;
    sample_data_i  = d;
    sample_first_i = f;
    @(negedge clk_x4_i);
    while (!sample_ready_o && n < 20) begin
      n++;
      @(negedge clk_x4_i);
    end
    if (!sample_ready_o) begin
      chk("accept_timeout", 32'd0, 32'd1);
      sample_valid_i = 1'b0;
      return;
    end
    if (exp_wr) sb_q.push_back({exp_addr, 8'h00, d});
    @(posedge clk_x4_i); #1;
    sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    @(negedge clk_x4_i);
    chk("wr_strobe_latency", {31'd0, ram_wr_en_o}, {31'd0, exp_wr});
  endtask

  task automatic send_frame(input logic [2:0] slot);
    for (int c = 0; c < 8; c++)
      send(24'(slot * 16 + c), c == 0, 1'b1, {slot, 3'(c)});
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk_x4_i) begin
    if (rst_ni === 1'b1 && ram_wr_en_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", {26'd0, ram_wr_addr_o}, 32'hFFFF_FFFF);
      end else begin
        logic [37:0] e;
        e = sb_q.pop_front();
        chk("sb_wr_addr", {26'd0, ram_wr_addr_o}, {26'd0, e[37:32]});
        chk("sb_wr_data", ram_wr_data_o, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_cnt;
    int n;
    rst_ni = 1'b0;
    sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    sample_data_i = 24'd0;
    set_rd(3'd0);
    repeat (3) @(posedge clk_x4_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_x4_i);
    chk("rst_wr_en", {31'd0, ram_wr_en_o}, 32'd0);
    chk("rst_last_good", {29'd0, last_good_frame_idx_o}, 32'd0);
    chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
    chk("rst_resync", {31'd0, resync_o}, 32'd0);
    chk("rst_overrun_cnt", {16'd0, overrun_cnt_o}, 32'd0);
    chk("rst_underrun_cnt", {16'd0, underrun_cnt_o}, 32'd0);
    chk("rst_ready_waitsync", {31'd0, sample_ready_o}, 32'd1);

    // First frame goes to slot 1 (word addresses 8..15).
    for (int c = 0; c < 8; c++) begin
      if (c == 7) chk("last_good_before_commit", {29'd0, last_good_frame_idx_o}, 32'd0);
      send(24'(c + 1), c == 0, 1'b1, 6'(8 + c));
    end
    chk("commit_slot1", {29'd0, last_good_frame_idx_o}, 32'd1);

    // Slots 2..7, then the write slot wraps onto the read slot and stalls.
    for (int s = 2; s < 8; s++) send_frame(3'(s));
    chk("commit_slot7", {29'd0, last_good_frame_idx_o}, 32'd7);
    chk("stall_on_wrap", {31'd0, sample_ready_o}, 32'd0);
    @(posedge clk_x4_i); #1;
    sample_valid_i = 1'b1;
    sample_first_i = 1'b1;
    sample_data_i = 24'h0000AA;
    repeat (5) @(posedge clk_x4_i);
    #1 sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    @(negedge clk_x4_i);
`ifdef ADAT_FRAME_SCHEDULER_STATS_EN
    chk("overrun_cnt_5", {16'd0, overrun_cnt_o}, 32'd5);
`else
    chk("overrun_cnt_off", {16'd0, overrun_cnt_o}, 32'd0);
`endif
    set_rd(3'd1);
    send_frame(3'd0);
    chk("commit_slot0", {29'd0, last_good_frame_idx_o}, 32'd0);
    chk("stall_slot1", {31'd0, sample_ready_o}, 32'd0);

    // Resync after three samples of slot 1.
    set_rd(3'd2);
    for (int c = 0; c < 3; c++) send(24'(16'h100 + c), c == 0, 1'b1, 6'(8 + c));
    send(24'h000200, 1'b1, 1'b1, 6'd8);
    chk("resync_pulse", {31'd0, resync_o}, 32'd1);
    send(24'h000201, 1'b0, 1'b1, 6'd9);
    chk("resync_one_cycle", {31'd0, resync_o}, 32'd0);
    for (int c = 2; c < 8; c++) send(24'(16'h200 + c), 1'b0, 1'b1, 6'(8 + c));
    chk("commit_after_resync", {29'd0, last_good_frame_idx_o}, 32'd1);

    // Underrun: last good = 2, encoder moves 2 -> 3 while slot 3 is half written.
    set_rd(3'd3);
    send_frame(3'd2);
    set_rd(3'd2);
    for (int c = 0; c < 4; c++) send(24'(16'h300 + c), c == 0, 1'b1, 6'(24 + c));
    chk("no_underrun_yet", {31'd0, underrun_o}, 32'd0);
    set_rd(3'd3);
    n = 0;
    @(negedge clk_x4_i);
    while (underrun_o !== 1'b1 && n < 6) begin
      n++;
      @(negedge clk_x4_i);
    end
    chk("underrun_pulse", {31'd0, underrun_o}, 32'd1);
    chk("underrun_keeps_last_good", {29'd0, last_good_frame_idx_o}, 32'd2);
`ifdef ADAT_FRAME_SCHEDULER_STATS_EN
    chk("underrun_cnt_1", {16'd0, underrun_cnt_o}, 32'd1);
`else
    chk("underrun_cnt_off", {16'd0, underrun_cnt_o}, 32'd0);
`endif
    @(negedge clk_x4_i);
    chk("underrun_one_cycle", {31'd0, underrun_o}, 32'd0);
    send(24'h000400, 1'b0, 1'b0, 6'd0);
    send(24'h000401, 1'b0, 1'b0, 6'd0);
    send_frame(3'd4);
    chk("commit_slot4", {29'd0, last_good_frame_idx_o}, 32'd4);

    // Reset in the middle of slot 5 (ch = 5).
    for (int c = 0; c < 5; c++) send(24'(16'h500 + c), c == 0, 1'b1, 6'(40 + c));
    @(posedge clk_x4_i); #1 rst_ni = 1'b0;
    @(posedge clk_x4_i); #1 rst_ni = 1'b1;
    @(negedge clk_x4_i);
    chk("midrst_last_good", {29'd0, last_good_frame_idx_o}, 32'd0);
    chk("midrst_wr_en", {31'd0, ram_wr_en_o}, 32'd0);
    chk("midrst_overrun_cnt", {16'd0, overrun_cnt_o}, 32'd0);
    chk("midrst_underrun_cnt", {16'd0, underrun_cnt_o}, 32'd0);
    send_frame(3'd1);
    send_frame(3'd2);
    chk("stall_slot3", {31'd0, sample_ready_o}, 32'd0);

    // Three more stall cycles, starting from a near-saturated counter when enabled.
    @(posedge clk_x4_i); #1;
`ifdef ADAT_FRAME_SCHEDULER_STATS_EN
    dut.overrun_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFF;
`else
    exp_cnt = 16'h0000;
`endif
    sample_valid_i = 1'b1;
    sample_first_i = 1'b1;
    repeat (3) @(posedge clk_x4_i);
    #1 sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    @(negedge clk_x4_i);
    chk("overrun_saturate", {16'd0, overrun_cnt_o}, {16'd0, exp_cnt});

    @(negedge clk_x4_i);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
